// File: rtl/bin_bcd_scan.sv
// bin_bcd_scan: binary-to-BCD converter and multiplexed digit scanner feeding a
// BCD->7-segment decoder.
//
// A sequential double-dabble engine converts bin_i (BIN_W bits) into N_DIG packed BCD
// digits, one input bit per clock. The result is committed to a display register only
// once the conversion completes, so the scanned digits never show partial results. An
// always-running scanner presents one digit at a time on bcd_o with a matching
// active-low anode select on an_o. Leading zeros are blanked (4'hF). Digit 0 is never
// blanked.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      synchronous, active-high reset
//   bin_i   in   BIN_W  binary value, sampled on an accepted load_i
//   load_i  in   1      start conversion; accepted only when idle and done_o is low
//   busy_o  out  1      conversion in progress
//   done_o  out  1      one-cycle pulse when the display register updates
//   bcd_o   out  4      BCD nibble of the selected digit (4'hF = blank)
//   an_o    out  N_DIG  one-hot active-low digit select

module bin_bcd_scan #(
  parameter int unsigned BIN_W       = 8,
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       bcd_o,
  output logic [N_DIG-1:0] an_o
);

  localparam int unsigned SW    = 4 * N_DIG;
  localparam int unsigned IterW = $clog2(BIN_W + 1);
  localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW  = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // The largest binary input must fit in N_DIG decimal digits.
  if (((64'd1 << BIN_W) - 64'd1) >= pow10(N_DIG)) begin : gen_width_chk
    $error("bin_bcd_scan: 2**BIN_W-1 does not fit in N_DIG decimal digits");
  end
  if (REFRESH_DIV < 1) begin : gen_div_chk
    $error("bin_bcd_scan: REFRESH_DIV must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [SW-1:0]    scr_q, scr_d;
  logic [SW-1:0]    disp_q, disp_d;
  logic [SW-1:0]    corr;
  logic [IterW-1:0] iter_q, iter_d;
  logic             busy_q, done_q;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             blank;

  // Converter next state
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    disp_d  = disp_q;
    iter_d  = iter_q;
    corr    = scr_q;
    unique case (state_q)
      StIdle: begin
        // done_q high means busy_o just fell; that cycle's load is dropped.
        if (load_i && !done_q) begin
          state_d = StShift;
          bin_d   = bin_i;
          scr_d   = '0;
          iter_d  = '0;
        end
      end
      StShift: begin
        for (int unsigned n = 0; n < N_DIG; n++) begin
          if (scr_q[n*4 +: 4] >= 4'd5) corr[n*4 +: 4] = scr_q[n*4 +: 4] + 4'd3;
        end
        {scr_d, bin_d} = {corr[SW-2:0], bin_q, 1'b0};
        iter_d = iter_q + IterW'(1);
        if (iter_q == IterW'(BIN_W - 1)) state_d = StDone;
      end
      StDone: begin
        disp_d  = scr_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scanner next state; anode and nibble are both derived from idx_d so they move together.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxW'(N_DIG - 1)) ? '0 : idx_q + IdxW'(1);
    end
    an_d  = ~(N_DIG'(1) << idx_d);
    // Blank when this digit and every more-significant digit are zero (never digit 0).
    blank = (idx_d != '0);
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if ((i >= 32'(idx_d)) && (disp_q[i*4 +: 4] != 4'd0)) blank = 1'b0;
    end
    bcd_d = blank ? 4'hF : disp_q[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      scr_q   <= '0;
      disp_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= ~(N_DIG'(1));
      bcd_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      disp_q  <= disp_d;
      iter_q  <= iter_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_q == StDone);
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign an_o   = an_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin_bcd_scan.sv
module tb_bin_bcd_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] bin_i = 8'd0;
  logic       busy_o, done_o;
  logic [3:0] bcd_o;
  logic [3:0] an_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bin_bcd_scan #(
    .BIN_W       (8),
    .N_DIG       (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bin_i  (bin_i),
    .load_i (load_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .bcd_o  (bcd_o),
    .an_o   (an_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] v);
    bin_i  = v;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  // Ticks until done_o is seen (bounded).
  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_o) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Collects the nibble shown for each anode position; packed as {d3,d2,d1,d0}.
  task automatic read_display(output logic [15:0] disp, output bit ok);
    logic [3:0] seen;
    logic [3:0] sel;
    seen = '0;
    disp = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        sel = ~(4'b0001 << d);
        if (an_o == sel) begin
          disp[d*4 +: 4] = bcd_o;
          seen[d] = 1'b1;
        end
      end
      if (&seen) break;
    end
    ok = &seen;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (an_o !== 4'b1110) $display("FAIL reset_an got=%b exp=1110", an_o);
    else passed++;
    checks++;
    if (bcd_o !== 4'h0) $display("FAIL reset_bcd got=%h exp=0", bcd_o);
    else passed++;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o);
    else passed++;
    checks++;
    if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o);
    else passed++;
  endtask

  task automatic test_scan;
    logic [3:0] exp_an;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_an = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (an_o !== exp_an) $display("FAIL scan_an cycle=%0d got=%b exp=%b", i, an_o, exp_an);
      else passed++;
      checks++;
      if ($countones(~an_o) != 1) $display("FAIL scan_onehot cycle=%0d got=%b exp=one low", i, an_o);
      else passed++;
    end
  endtask

  task automatic test_convert_255;
    int n;
    logic [15:0] got;
    bit ok;
    start_load(8'd255);
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 9) $display("FAIL busy_len got=%0d exp=9", n);
    else passed++;
    checks++;
    if (done_o !== 1'b1) $display("FAIL done_at_k9 got=%b exp=1", done_o);
    else passed++;
    tick();
    checks++;
    if (done_o !== 1'b0) $display("FAIL done_width got=%b exp=0", done_o);
    else passed++;
    read_display(got, ok);
    checks++;
    if (!ok || got !== 16'hF255) $display("FAIL disp_255 got=%h exp=f255", got);
    else passed++;
  endtask

  task automatic test_values;
    logic [7:0]  vals [3];
    logic [15:0] exps [3];
    logic [15:0] got;
    bit ok, found;
    vals[0] = 8'd7;   exps[0] = 16'hFFF7;
    vals[1] = 8'd0;   exps[1] = 16'hFFF0;
    vals[2] = 8'd100; exps[2] = 16'hF100;
    for (int t = 0; t < 3; t++) begin
      start_load(vals[t]);
      wait_done(found);
      checks++;
      if (!found) $display("FAIL value_done v=%0d got=no pulse exp=pulse", vals[t]);
      else passed++;
      tick();
      read_display(got, ok);
      checks++;
      if (!ok || got !== exps[t]) $display("FAIL disp_value v=%0d got=%h exp=%h", vals[t], got, exps[t]);
      else passed++;
    end
  endtask

  task automatic test_ignore_load;
    int pulses;
    bit found, ok;
    logic [15:0] got;
    start_load(8'd100);
    tick();
    tick();
    start_load(8'd42);  // edge k+3, mid-conversion
    pulses = 0;
    wait_done(found);
    if (found) pulses++;
    // Load during the done_o cycle must also be dropped.
    bin_i  = 8'd42;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL load_at_busy_fall got=%b exp=0", busy_o);
    else passed++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_o) pulses++;
    end
    checks++;
    if (pulses != 1) $display("FAIL done_count got=%0d exp=1", pulses);
    else passed++;
    read_display(got, ok);
    checks++;
    if (!ok || got !== 16'hF100) $display("FAIL disp_ignore got=%h exp=f100", got);
    else passed++;
    start_load(8'd42);
    checks++;
    if (busy_o !== 1'b1) $display("FAIL reaccept got=%b exp=1", busy_o);
    else passed++;
    wait_done(found);
    tick();
    read_display(got, ok);
    checks++;
    if (!ok || got !== 16'hFF42) $display("FAIL disp_42 got=%h exp=ff42", got);
    else passed++;
  endtask

  task automatic test_reset_abort;
    bit found, ok;
    int pulses;
    logic [15:0] got;
    logic [15:0] shown;
    logic [3:0]  exp_nib;
    logic [3:0]  sel;
    shown = 16'hF255;
    start_load(8'd255);
    wait_done(found);
    tick();
    start_load(8'd37);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_nib = 4'hX;
      for (int d = 0; d < 4; d++) begin
        sel = ~(4'b0001 << d);
        if (an_o == sel) exp_nib = shown[d*4 +: 4];
      end
      checks++;
      if (bcd_o !== exp_nib) $display("FAIL hold_display cycle=%0d got=%h exp=%h", i, bcd_o, exp_nib);
      else passed++;
    end
    rst = 1'b1;
    tick();  // edge k+4
    rst = 1'b0;
    checks++;
    if (busy_o !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy_o);
    else passed++;
    checks++;
    if (an_o !== 4'b1110 || bcd_o !== 4'h0)
      $display("FAIL abort_scan got=%b/%h exp=1110/0", an_o, bcd_o);
    else passed++;
    pulses = 0;
    if (done_o) pulses++;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_o) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL abort_done got=%0d exp=0", pulses);
    else passed++;
    read_display(got, ok);
    checks++;
    if (!ok || got !== 16'hFFF0) $display("FAIL abort_disp got=%h exp=fff0", got);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert_255();
    test_values();
    test_ignore_load();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
